// File: rtl/lock_code_sender.sv
// Serial code transmitter for the sequential lock: shifts a latched code out MSB first,
// then waits for the lock's unlocked feedback and retries on timeout.
module lock_code_sender #(
    parameter int unsigned CODE_LEN  = 4,
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned MAX_RETRY = 3,
    localparam int unsigned AttW     = $clog2(MAX_RETRY + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                abort,
    input  logic                unlocked,
    output logic                x,
    output logic                x_valid,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [AttW-1:0]     attempt
);

    localparam int unsigned BitW  = $clog2(CODE_LEN);
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StSend = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StDone = 3'd3;
    localparam logic [2:0] StFail = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [AttW-1:0]     attempt_d;
    logic [BitW-1:0]     bit_idx;
    logic                x_d, x_valid_d, busy_d, done_d, fail_d;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        attempt_d  = attempt;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    code_d    = code_in;
                    attempt_d = AttW'(1);
                    bit_cnt_d = '0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_cnt_q == BitW'(CODE_LEN - 1)) begin
                    // Only the final bit's cycle may report early success (Mealy lock).
                    wait_cnt_d = '0;
                    state_d    = unlocked ? StDone : StWait;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (unlocked) begin
                    state_d = StDone;
                end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
                    wait_cnt_d = '0;
                    if (attempt <= AttW'(MAX_RETRY)) begin
                        attempt_d = attempt + 1'b1;
                        bit_cnt_d = '0;
                        state_d   = StSend;
                    end else begin
                        state_d = StFail;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StDone, StFail: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        bit_idx   = BitW'(CODE_LEN - 1) - bit_cnt_d;
        x_valid_d = (state_d == StSend);
        x_d       = x_valid_d ? code_d[bit_idx] : 1'b0;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        fail_d    = (state_d == StFail);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            code_q     <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            attempt    <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            attempt    <= attempt_d;
            x          <= x_d;
            x_valid    <= x_valid_d;
            busy       <= busy_d;
            done       <= done_d;
            fail       <= fail_d;
        end
    end

endmodule
